// File: rtl/pheap_stage_pkg.sv
// Shared types for the pipelined heap: level entries, token opcodes and stage states.
package pheap_stage_pkg;

  localparam int unsigned LEVELS = 4;

  typedef logic [LEVELS-1:0] pos_t;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_POP    = 1'b1
  } op_t;

  // cap counts the free slots in the subtree rooted at this node
  typedef struct packed {
    logic [31:0] value;
    pos_t        cap;
    logic        occ;
  } entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StOut,
    StWaitUp
  } state_t;

  function automatic entry_t mk_entry(logic [31:0] value, pos_t cap, logic occ);
    entry_t e;
    e.value = value;
    e.cap   = cap;
    e.occ   = occ;
    return e;
  endfunction

endpackage

// File: rtl/pheap_select.sv
// Sibling chooser: inserts go toward the roomier subtree, pops take the smaller occupied child.
module pheap_select
  import pheap_stage_pkg::*;
(
  input  op_t    op,
  input  entry_t a,
  input  entry_t b,
  output logic   pick_b,
  output entry_t chosen
);

  always_comb begin
    pick_b = 1'b0;
    if (op == OP_INSERT) begin
      pick_b = b.cap > a.cap;
    end else if (a.occ && b.occ) begin
      pick_b = b.value < a.value;
    end else begin
      pick_b = b.occ && !a.occ;
    end
    chosen = pick_b ? b : a;
  end

endmodule

// File: rtl/pheap_stage.sv
// One level of the pipelined heap: reads a sibling pair, updates this level or the
// parent hole, and hands the displaced/refill token to the next level down.
module pheap_stage
  import pheap_stage_pkg::*;
#(
  parameter int unsigned LEVELS = pheap_stage_pkg::LEVELS,
  parameter int unsigned LEVEL  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  op_t         in_op,
  input  logic [31:0] in_value,
  input  pos_t        in_pos,
  input  pos_t        in_cap,
  output logic        out_valid,
  input  logic        out_ready,
  output op_t         out_op,
  output logic [31:0] out_value,
  output pos_t        out_pos,
  output pos_t        out_cap,
  output logic        rd_en,
  output pos_t        rd_addr_a,
  output pos_t        rd_addr_b,
  input  entry_t      rd_data_a,
  input  entry_t      rd_data_b,
  output logic        wr_en,
  output pos_t        wr_addr,
  output entry_t      wr_data,
  output logic        up_wen,
  output pos_t        up_addr,
  output entry_t      up_data,
  input  logic        dn_wen,
  output logic        res_valid,
  output logic [31:0] res_value,
  output logic        err_full,
  output logic        err_empty
);

  localparam bit IsRoot = (LEVEL == 0);
  localparam bit IsLast = (LEVEL == LEVELS - 1);

  state_t      state_q, state_d;
  op_t         op_q;
  logic [31:0] value_q;
  pos_t        pos_q, cap_q;
  op_t         out_op_q, out_op_d;
  logic [31:0] out_value_q, out_value_d;
  pos_t        out_pos_q, out_pos_d, out_cap_q, out_cap_d;

  pos_t   addr_in, tok_base, n_addr;
  entry_t sib_b, chosen;
  logic   pick_b, fwd, keep_res;

  // The root level holds a single node; its phantom sibling is always empty.
  assign addr_in  = IsRoot ? '0 : {in_pos[LEVELS-2:0], 1'b0};
  assign tok_base = IsRoot ? '0 : {pos_q[LEVELS-2:0], 1'b0};
  assign sib_b    = IsRoot ? '0 : rd_data_b;
  assign n_addr   = {tok_base[LEVELS-1:1], pick_b};
  assign keep_res = !(value_q < chosen.value);

  assign rd_addr_a = rst ? '0 : addr_in;
  assign rd_addr_b = rst ? '0 : {addr_in[LEVELS-1:1], 1'b1};

  pheap_select u_select (
    .op     (op_q),
    .a      (rd_data_a),
    .b      (sib_b),
    .pick_b (pick_b),
    .chosen (chosen)
  );

  always_comb begin
    state_d     = state_q;
    out_op_d    = out_op_q;
    out_value_d = out_value_q;
    out_pos_d   = out_pos_q;
    out_cap_d   = out_cap_q;
    in_ready    = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    up_wen      = 1'b0;
    up_addr     = '0;
    up_data     = '0;
    res_valid   = 1'b0;
    res_value   = '0;
    err_full    = 1'b0;
    err_empty   = 1'b0;
    fwd         = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          in_ready = 1'b1;
          rd_en    = in_valid;
          if (in_valid) state_d = StExec;
        end
        StExec: begin
          state_d = StIdle;
          if (op_q == OP_INSERT) begin
            if (chosen.cap == '0) begin
              err_full = 1'b1;
            end else begin
              wr_en   = 1'b1;
              wr_addr = n_addr;
              if (!chosen.occ) begin
                wr_data = mk_entry(value_q, chosen.cap - 1'b1, 1'b1);
              end else begin
                // Ties leave the resident in place and push the newcomer down.
                wr_data     = mk_entry(keep_res ? chosen.value : value_q,
                                       chosen.cap - 1'b1, 1'b1);
                fwd         = 1'b1;
                out_op_d    = OP_INSERT;
                out_value_d = keep_res ? value_q : chosen.value;
                out_pos_d   = n_addr;
                out_cap_d   = '0;
              end
            end
          end else if (IsRoot) begin
            if (!rd_data_a.occ) begin
              err_empty = 1'b1;
            end else begin
              res_valid   = 1'b1;
              res_value   = rd_data_a.value;
              fwd         = 1'b1;
              out_op_d    = OP_POP;
              out_value_d = '0;
              out_pos_d   = '0;
              out_cap_d   = rd_data_a.cap;
            end
          end else if (rd_data_a.occ || sib_b.occ) begin
            up_wen  = 1'b1;
            up_addr = pos_q;
            up_data = mk_entry(chosen.value, cap_q + 1'b1, 1'b1);
            if (IsLast) begin
              wr_en   = 1'b1;
              wr_addr = n_addr;
              wr_data = mk_entry('0, chosen.cap + 1'b1, 1'b0);
            end else begin
              fwd         = 1'b1;
              out_op_d    = OP_POP;
              out_value_d = chosen.value;
              out_pos_d   = n_addr;
              out_cap_d   = chosen.cap;
            end
          end else begin
            up_wen  = 1'b1;
            up_addr = pos_q;
            up_data = mk_entry('0, cap_q + 1'b1, 1'b0);
          end
          if (fwd && !IsLast) state_d = StOut;
        end
        StOut: begin
          if (out_ready) state_d = (out_op_q == OP_POP) ? StWaitUp : StIdle;
        end
        StWaitUp: begin
          // Hold off the next read until the child has refilled our hole.
          if (dn_wen) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign out_valid = (state_q == StOut) && !IsLast && !rst;
  assign out_op    = out_valid ? out_op_q : OP_INSERT;
  assign out_value = out_valid ? out_value_q : '0;
  assign out_pos   = out_valid ? out_pos_q : '0;
  assign out_cap   = out_valid ? out_cap_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OP_INSERT;
      value_q     <= '0;
      pos_q       <= '0;
      cap_q       <= '0;
      out_op_q    <= OP_INSERT;
      out_value_q <= '0;
      out_pos_q   <= '0;
      out_cap_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_op_q    <= out_op_d;
      out_value_q <= out_value_d;
      out_pos_q   <= out_pos_d;
      out_cap_q   <= out_cap_d;
      if (rd_en) begin
        op_q    <= in_op;
        value_q <= in_value;
        pos_q   <= in_pos;
        cap_q   <= in_cap;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pos_q, cap_q, rd_data_b, dn_wen, in_pos[LEVELS-1]};

endmodule

// File: tb/tb_pheap_stage.sv
// Bench for pheap_stage: root, middle and last-level instances driven by directed vectors,
// random vectors scored by a rule-level model, and stall/reset/wait-up sequences.
`timescale 1ns/1ps
module tb_pheap_stage;
  import pheap_stage_pkg::*;

  localparam int NI = 3;

  typedef struct {
    logic        wr_en;
    pos_t        wr_addr;
    entry_t      wr_data;
    logic        up_wen;
    pos_t        up_addr;
    entry_t      up_data;
    logic        res_valid;
    logic [31:0] res_value;
    logic        err_full;
    logic        err_empty;
    logic        fwd;
    op_t         out_op;
    logic [31:0] out_value;
    pos_t        out_pos;
    pos_t        out_cap;
  } exp_t;

  typedef struct {
    int          k;
    op_t         op;
    logic [31:0] value;
    pos_t        pos;
    pos_t        cap;
    entry_t      a;
    entry_t      b;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid [NI];
  logic out_ready [NI];
  logic dn_wen [NI];
  op_t in_op;
  logic [31:0] in_value;
  pos_t in_pos, in_cap;
  entry_t rd_data_a, rd_data_b;

  logic in_ready [NI], out_valid [NI], rd_en [NI], wr_en [NI], up_wen [NI];
  logic res_valid [NI], err_full [NI], err_empty [NI];
  op_t out_op [NI];
  logic [31:0] out_value [NI], res_value [NI];
  pos_t out_pos [NI], out_cap [NI], rd_addr_a [NI], rd_addr_b [NI], wr_addr [NI], up_addr [NI];
  entry_t wr_data [NI], up_data [NI];

  int n_pass = 0;
  int n_tot = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pheap_stage #(
      .LEVELS (4),
      .LEVEL  ((g == 0) ? 0 : (g == 1) ? 1 : 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_op     (in_op),
      .in_value  (in_value),
      .in_pos    (in_pos),
      .in_cap    (in_cap),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_op    (out_op[g]),
      .out_value (out_value[g]),
      .out_pos   (out_pos[g]),
      .out_cap   (out_cap[g]),
      .rd_en     (rd_en[g]),
      .rd_addr_a (rd_addr_a[g]),
      .rd_addr_b (rd_addr_b[g]),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .wr_en     (wr_en[g]),
      .wr_addr   (wr_addr[g]),
      .wr_data   (wr_data[g]),
      .up_wen    (up_wen[g]),
      .up_addr   (up_addr[g]),
      .up_data   (up_data[g]),
      .dn_wen    (dn_wen[g]),
      .res_valid (res_valid[g]),
      .res_value (res_value[g]),
      .err_full  (err_full[g]),
      .err_empty (err_empty[g])
    );
  end

  function automatic int lvl(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  function automatic entry_t ent(int value, int cap, int occ);
    return mk_entry(32'(value), pos_t'(cap), occ[0]);
  endfunction

  function automatic exp_t ex(int we, int wa, entry_t wd, int ue, int ua, entry_t ud,
                              int rv, int rval, int ef, int ee, int fw, op_t oo,
                              int ov, int op_, int oc);
    exp_t e;
    e.wr_en = we[0]; e.wr_addr = pos_t'(wa); e.wr_data = wd;
    e.up_wen = ue[0]; e.up_addr = pos_t'(ua); e.up_data = ud;
    e.res_valid = rv[0]; e.res_value = 32'(rval);
    e.err_full = ef[0]; e.err_empty = ee[0];
    e.fwd = fw[0]; e.out_op = oo; e.out_value = 32'(ov);
    e.out_pos = pos_t'(op_); e.out_cap = pos_t'(oc);
    return e;
  endfunction

  // Rule-level reference: pick a node from the pair, then apply the op's outcome.
  function automatic exp_t model(int k, op_t op, logic [31:0] value, pos_t pos, pos_t cap,
                                 entry_t a, entry_t b);
    exp_t e;
    int lv, base, n;
    entry_t s [2];
    int occ_idx [$];
    e = ex(0, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0, OP_INSERT, 0, 0, 0);
    lv = lvl(k);
    base = (lv == 0) ? 0 : (int'(pos) * 2) % 16;
    s[0] = a;
    s[1] = (lv == 0) ? entry_t'('0) : b;
    if (op == OP_INSERT) begin
      n = (s[1].cap > s[0].cap) ? 1 : 0;
      if (s[n].cap == 0) begin
        e.err_full = 1'b1;
      end else begin
        e.wr_en = 1'b1;
        e.wr_addr = pos_t'(base + n);
        if (!s[n].occ) begin
          e.wr_data = ent(int'(value), int'(s[n].cap) - 1, 1);
        end else if (s[n].value <= value) begin
          e.wr_data = ent(int'(s[n].value), int'(s[n].cap) - 1, 1);
          e.fwd = (lv != 3); e.out_value = value; e.out_pos = pos_t'(base + n);
        end else begin
          e.wr_data = ent(int'(value), int'(s[n].cap) - 1, 1);
          e.fwd = (lv != 3); e.out_value = s[n].value; e.out_pos = pos_t'(base + n);
        end
      end
    end else if (lv == 0) begin
      if (!a.occ) begin
        e.err_empty = 1'b1;
      end else begin
        e.res_valid = 1'b1; e.res_value = a.value;
        e.fwd = 1'b1; e.out_op = OP_POP; e.out_pos = '0; e.out_cap = a.cap;
      end
    end else begin
      foreach (s[i]) if (s[i].occ) occ_idx.push_back(i);
      e.up_wen = 1'b1;
      e.up_addr = pos;
      if (occ_idx.size() == 0) begin
        e.up_data = ent(0, (int'(cap) + 1) % 16, 0);
      end else begin
        n = occ_idx[0];
        foreach (occ_idx[j]) if (s[occ_idx[j]].value < s[n].value) n = occ_idx[j];
        e.up_data = ent(int'(s[n].value), (int'(cap) + 1) % 16, 1);
        if (lv == 3) begin
          e.wr_en = 1'b1; e.wr_addr = pos_t'(base + n);
          e.wr_data = ent(0, (int'(s[n].cap) + 1) % 16, 0);
        end else begin
          e.fwd = 1'b1; e.out_op = OP_POP; e.out_pos = pos_t'(base + n); e.out_cap = s[n].cap;
        end
      end
    end
    return e;
  endfunction

  task automatic drive(input vec_t v);
    in_op = v.op; in_value = v.value; in_pos = v.pos; in_cap = v.cap;
    rd_data_a = v.a; rd_data_b = v.b;
  endtask

  // Full transaction; dn_delay holds the child's write-back off for that many cycles.
  task automatic run_vec(input vec_t v, input string tag, input int dn_delay);
    int k, base;
    k = v.k;
    base = (lvl(k) == 0) ? 0 : (int'(v.pos) * 2) % 16;
    @(negedge clk);
    drive(v);
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b1;
    #1;
    chk({tag, " in_ready"}, in_ready[k], 1);
    chk({tag, " rd_en"}, rd_en[k], 1);
    chk({tag, " rd_addr_a"}, rd_addr_a[k], base);
    if (lvl(k) != 0) chk({tag, " rd_addr_b"}, rd_addr_b[k], base + 1);
    @(negedge clk);
    in_valid[k] = 1'b0;
    chk({tag, " exec in_ready"}, in_ready[k], 0);
    chk({tag, " wr_en"}, wr_en[k], v.e.wr_en);
    if (v.e.wr_en) begin
      chk({tag, " wr_addr"}, wr_addr[k], v.e.wr_addr);
      chk({tag, " wr_data"}, wr_data[k], v.e.wr_data);
    end
    chk({tag, " up_wen"}, up_wen[k], v.e.up_wen);
    if (v.e.up_wen) begin
      chk({tag, " up_addr"}, up_addr[k], v.e.up_addr);
      chk({tag, " up_data"}, up_data[k], v.e.up_data);
    end
    chk({tag, " res_valid"}, res_valid[k], v.e.res_valid);
    if (v.e.res_valid) chk({tag, " res_value"}, res_value[k], v.e.res_value);
    chk({tag, " err_full"}, err_full[k], v.e.err_full);
    chk({tag, " err_empty"}, err_empty[k], v.e.err_empty);
    @(negedge clk);
    chk({tag, " out_valid"}, out_valid[k], v.e.fwd);
    chk({tag, " wr_en c2"}, wr_en[k], 0);
    if (v.e.fwd) begin
      chk({tag, " out_op"}, out_op[k], v.e.out_op);
      chk({tag, " out_pos"}, out_pos[k], v.e.out_pos);
      if (v.op == OP_INSERT) chk({tag, " out_value"}, out_value[k], v.e.out_value);
      else chk({tag, " out_cap"}, out_cap[k], v.e.out_cap);
      chk({tag, " out in_ready"}, in_ready[k], 0);
      @(negedge clk);
      if (v.op == OP_POP) begin
        for (int d = 0; d < dn_delay; d++) begin
          chk({tag, " wait in_ready"}, in_ready[k], 0);
          @(negedge clk);
        end
        chk({tag, " wait in_ready"}, in_ready[k], 0);
        dn_wen[k] = 1'b1;
        @(negedge clk);
        dn_wen[k] = 1'b0;
      end
    end
    chk({tag, " done in_ready"}, in_ready[k], 1);
  endtask

  task automatic accept(input vec_t v);
    @(negedge clk);
    drive(v);
    in_valid[v.k] = 1'b1;
    out_ready[v.k] = 1'b0;
    @(negedge clk);
    in_valid[v.k] = 1'b0;
  endtask

  vec_t vecs [$];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (in_valid[i]) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1; dn_wen[i] = 1'b0;
    end
    in_op = OP_INSERT; in_value = '0; in_pos = '0; in_cap = '0;
    rd_data_a = '0; rd_data_b = '0;

    // Reset: outputs quiet while rst is high even with a pending request.
    rst = 1'b1;
    in_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready[0], 0);
    chk("rst rd_en", rd_en[0], 0);
    chk("rst out_valid", out_valid[1], 0);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", in_ready[0], 1);

    vecs.push_back('{0, OP_INSERT, 7, 0, 0, ent(0, 15, 0), ent(0, 0, 0),
      ex(1, 0, ent(7, 14, 1), 0, 0, '0, 0, 0, 0, 0, 0, OP_INSERT, 0, 0, 0)});
    vecs.push_back('{0, OP_INSERT, 3, 0, 0, ent(5, 14, 1), ent(0, 0, 0),
      ex(1, 0, ent(3, 13, 1), 0, 0, '0, 0, 0, 0, 0, 1, OP_INSERT, 5, 0, 0)});
    vecs.push_back('{1, OP_POP, 0, 0, 13, ent(9, 6, 1), ent(4, 7, 1),
      ex(0, 0, '0, 1, 0, ent(4, 14, 1), 0, 0, 0, 0, 1, OP_POP, 0, 1, 7)});
    vecs.push_back('{2, OP_POP, 0, 2, 5, ent(8, 0, 1), ent(0, 1, 0),
      ex(1, 4, ent(0, 1, 0), 1, 2, ent(8, 6, 1), 0, 0, 0, 0, 0, OP_INSERT, 0, 0, 0)});
    vecs.push_back('{0, OP_INSERT, 9, 0, 0, ent(9, 0, 1), ent(0, 0, 0),
      ex(0, 0, '0, 0, 0, '0, 0, 0, 1, 0, 0, OP_INSERT, 0, 0, 0)});
    vecs.push_back('{0, OP_POP, 0, 0, 0, ent(0, 15, 0), ent(0, 0, 0),
      ex(0, 0, '0, 0, 0, '0, 0, 0, 0, 1, 0, OP_INSERT, 0, 0, 0)});
    vecs.push_back('{0, OP_POP, 0, 0, 0, ent(5, 14, 1), ent(1, 15, 1),
      ex(0, 0, '0, 0, 0, '0, 1, 5, 0, 0, 1, OP_POP, 0, 0, 14)});
    vecs.push_back('{1, OP_INSERT, 6, 1, 0, ent(6, 3, 1), ent(2, 3, 1),
      ex(1, 2, ent(6, 2, 1), 0, 0, '0, 0, 0, 0, 0, 1, OP_INSERT, 6, 2, 0)});
    vecs.push_back('{1, OP_POP, 0, 3, 15, ent(1, 1, 0), ent(2, 1, 0),
      ex(0, 0, '0, 1, 3, ent(0, 0, 0), 0, 0, 0, 0, 0, OP_INSERT, 0, 0, 0)});
    vecs.push_back('{1, OP_POP, 0, 1, 2, ent(4, 3, 1), ent(4, 5, 1),
      ex(0, 0, '0, 1, 1, ent(4, 3, 1), 0, 0, 0, 0, 1, OP_POP, 0, 2, 3)});
    vecs.push_back('{1, OP_INSERT, 10, 2, 0, ent(3, 2, 1), ent(12, 5, 1),
      ex(1, 5, ent(10, 4, 1), 0, 0, '0, 0, 0, 0, 0, 1, OP_INSERT, 12, 5, 0)});
    vecs.push_back('{2, OP_INSERT, 4, 5, 0, ent(7, 0, 1), ent(0, 1, 0),
      ex(1, 11, ent(4, 0, 1), 0, 0, '0, 0, 0, 0, 0, 0, OP_INSERT, 0, 0, 0)});
    vecs.push_back('{1, OP_POP, 0, 0, 3, ent(0, 4, 0), ent(9, 2, 1),
      ex(0, 0, '0, 1, 0, ent(9, 4, 1), 0, 0, 0, 0, 1, OP_POP, 0, 1, 2)});

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

    for (int i = 0; i < 60; i++) begin
      v.k = int'($urandom_range(0, 2));
      v.op = $urandom_range(0, 1) ? OP_POP : OP_INSERT;
      v.value = 32'($urandom_range(0, 15));
      v.pos = pos_t'($urandom_range(0, 7));
      v.cap = pos_t'($urandom_range(0, 15));
      v.a = ent(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)));
      v.b = ent(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)));
      v.e = model(v.k, v.op, v.value, v.pos, v.cap, v.a, v.b);
      run_vec(v, $sformatf("rnd%0d", i), int'($urandom_range(0, 2)));
    end

    // Parent waits in WAIT_UP until the child's write-back arrives.
    run_vec(vecs[2], "waitup", 3);

    // Downstream stall: forwarded insert held stable for five cycles.
    accept(vecs[1]);
    chk("stall wr_en", wr_en[0], 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", c), out_valid[0], 1);
      chk($sformatf("stall%0d out_value", c), out_value[0], 5);
      chk($sformatf("stall%0d out_pos", c), out_pos[0], 0);
      chk($sformatf("stall%0d in_ready", c), in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("stall release out_valid", out_valid[0], 0);
    chk("stall release in_ready", in_ready[0], 1);

    // Reset while a forwarded token waits: token dropped, no writes.
    accept(vecs[1]);
    @(negedge clk);
    chk("rstout out_valid", out_valid[0], 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstout during out_valid", out_valid[0], 0);
    chk("rstout during wr_en", wr_en[0], 0);
    chk("rstout during in_ready", in_ready[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstout after out_valid", out_valid[0], 0);
    chk("rstout after wr_en", wr_en[0], 0);
    chk("rstout after in_ready", in_ready[0], 1);
    out_ready[0] = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
